// File: rtl/prbs_checker.sv
// ============================================================================
//  prbs_checker : aligns to the 8-bit LFSR stream and counts bit errors
//  Rev 1.0
// ============================================================================
`default_nettype none

module prbs_checker #(
    parameter int N        = 8,
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          bit_valid,
    input  logic          bit_in,
    input  logic          clear,
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] bits_checked
);

    typedef enum logic [0:0] {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    localparam int FW = $clog2(N + 1);
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam int EW = $clog2(LOSS_THR + 1);

    localparam logic [FW-1:0] c_FILL_DONE = FW'(N);
    localparam logic [RW-1:0] c_RUN_LAST  = RW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] c_WIN_LAST  = WW'(WIN - 1);
    localparam logic [EW-1:0] c_LOSS_LAST = EW'(LOSS_THR - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [N-1:0]  r_hist;
    logic [FW-1:0] r_fill;
    logic [RW-1:0] r_run;
    logic [WW-1:0] r_win_cnt;
    logic [EW-1:0] r_win_err;
    logic          r_locked;
    logic          r_err_pulse;
    logic [CW-1:0] r_err_count;
    logic [CW-1:0] r_bits_checked;

    logic w_pred;
    logic w_match;
    logic w_filled;
    logic w_hist_zero;
    logic w_err;
    logic w_win_end;

    assign w_pred      = r_hist[N-1] ^ r_hist[N-3] ^ r_hist[N-5];
    assign w_match     = (bit_in == w_pred);
    assign w_filled    = (r_fill == c_FILL_DONE);
    assign w_hist_zero = (r_hist == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_win_end    = 1'b0;
        if (bit_valid) begin
            case (r_state)
                S_SEARCH: begin
                    // An all-zero history trivially satisfies the recurrence, so it never counts
                    if (w_filled && w_match && !w_hist_zero && (r_run == c_RUN_LAST)) begin
                        w_state_next = S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    w_err     = !w_match;
                    w_win_end = (r_win_cnt == c_WIN_LAST);
                    if (w_err && (r_win_err == c_LOSS_LAST)) begin
                        w_state_next = S_SEARCH;
                    end
                end
                default: w_state_next = S_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist         <= '0;
            r_fill         <= '0;
            r_run          <= '0;
            r_win_cnt      <= '0;
            r_win_err      <= '0;
            r_locked       <= 1'b0;
            r_err_pulse    <= 1'b0;
            r_err_count    <= '0;
            r_bits_checked <= '0;
        end else begin
            r_locked    <= (w_state_next == S_LOCKED);
            r_err_pulse <= w_err;

            if (bit_valid) begin
                if (r_state == S_SEARCH) begin
                    r_hist <= {r_hist[N-2:0], bit_in};
                    if (!w_filled) begin
                        r_fill <= r_fill + FW'(1);
                    end else if (w_match && !w_hist_zero) begin
                        r_run <= r_run + RW'(1);
                    end else begin
                        r_run <= '0;
                    end
                    if (w_state_next == S_LOCKED) begin
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                    end
                end else begin
                    // Flywheel on the prediction so a line error cannot corrupt later checks
                    r_hist <= {r_hist[N-2:0], w_pred};
                    if (w_win_end) begin
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + WW'(1);
                        if (w_err) begin
                            r_win_err <= r_win_err + EW'(1);
                        end
                    end
                    if (w_state_next == S_SEARCH) begin
                        r_fill <= '0;
                        r_run  <= '0;
                    end
                end
            end

            if (clear) begin
                r_err_count    <= '0;
                r_bits_checked <= '0;
            end else begin
                if (bit_valid && (r_state == S_LOCKED) && (r_bits_checked != '1)) begin
                    r_bits_checked <= r_bits_checked + CW'(1);
                end
                if (w_err && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + CW'(1);
                end
            end
        end
    end

    assign locked       = r_locked;
    assign err_pulse    = r_err_pulse;
    assign err_count    = r_err_count;
    assign bits_checked = r_bits_checked;

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// ============================================================================
//  tb_prbs_checker : scenario table plus cycle scoreboard for prbs_checker
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        bit_valid;
    logic        bit_in;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] bits_checked;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk          (clk),
        .reset        (reset),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .clear        (clear),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .bits_checked (bits_checked)
    );

    typedef struct {
        int   nbits;
        int   vpct;
        bit   zero;
        int   e_lo;
        int   e_hi;
        int   exp_lock_at;
        int   exp_err;
        int   exp_bits;
        logic exp_locked;
        int   exp_pulses;
    } row_t;

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [15:0] bc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stream[0:1023];

    // Behavioural reference, hard-wired for N=8 taps 7/5/3
    logic [7:0] m_h;
    int         m_fill, m_run, m_wc, m_we, m_ec, m_bc;
    logic       m_lk, m_ep;

    task automatic model_reset();
        m_h = '0; m_fill = 0; m_run = 0; m_wc = 0; m_we = 0;
        m_ec = 0; m_bc = 0; m_lk = 1'b0; m_ep = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic c);
        logic p;
        m_ep = 1'b0;
        if (v) begin
            p = m_h[7] ^ m_h[5] ^ m_h[3];
            if (!m_lk) begin
                if (m_fill < 8) m_fill++;
                else if (b == p && m_h != 8'h00) begin
                    m_run++;
                    if (m_run == 16) begin m_lk = 1'b1; m_wc = 0; m_we = 0; end
                end else m_run = 0;
                m_h = {m_h[6:0], b};
            end else begin
                m_h = {m_h[6:0], p};
                if (m_bc < 65535) m_bc++;
                m_wc++;
                if (b != p) begin
                    m_ep = 1'b1;
                    m_we++;
                    if (m_ec < 65535) m_ec++;
                end
                if (m_we >= 8) begin m_lk = 1'b0; m_fill = 0; m_run = 0; end
                if (m_wc == 64) begin m_wc = 0; m_we = 0; end
            end
        end
        if (c) begin m_ec = 0; m_bc = 0; end
    endtask

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        exp_t e;
        @(negedge clk);
        bit_valid = v; bit_in = b; clear = c;
        model_step(v, b, c);
        sb_q.push_back({m_lk, m_ep, 16'(m_ec), 16'(m_bc)});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("cycle{lk,ep,ec,bc}", {locked, err_pulse, err_count, bits_checked}, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; bit_valid = 1'b0; clear = 1'b0; bit_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_row(input int idx, input row_t r);
        int   vcnt    = 0;
        int   lock_at = 0;
        int   pulses  = 0;
        int   cyc     = 0;
        logic v, b;
        do_reset();
        while (vcnt < r.nbits && cyc < 5000) begin
            cyc++;
            v = (r.vpct >= 100) ? 1'b1 : ($urandom_range(0, 99) < r.vpct);
            if (v) begin
                vcnt++;
                b = r.zero ? 1'b0 : stream[vcnt-1];
                if (vcnt >= r.e_lo && vcnt <= r.e_hi) b = ~b;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(v, b, 1'b0);
            if (err_pulse) pulses++;
            if (locked && lock_at == 0) lock_at = vcnt;
        end
        check($sformatf("row%0d_bits_done", idx), 34'(vcnt), 34'(r.nbits));
        check($sformatf("row%0d_lock_at", idx), 34'(lock_at), 34'(r.exp_lock_at));
        check($sformatf("row%0d_err_count", idx), 34'(err_count), 34'(r.exp_err));
        check($sformatf("row%0d_bits_checked", idx), 34'(bits_checked), 34'(r.exp_bits));
        check($sformatf("row%0d_locked", idx), 34'(locked), 34'(r.exp_locked));
        check($sformatf("row%0d_pulses", idx), 34'(pulses), 34'(r.exp_pulses));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        row_t rows[7];
        logic [7:0] seed;

        // nbits vpct zero e_lo e_hi lock_at err bits locked pulses
        rows[0] = '{200, 100, 1'b0,  0, -1, 24,  0, 176, 1'b1,  0};
        rows[1] = '{100, 100, 1'b0, 50, 50, 24,  1,  76, 1'b1,  1};
        rows[2] = '{300, 100, 1'b1,  0, -1,  0,  0,   0, 1'b0,  0};
        rows[3] = '{ 50, 100, 1'b0, 25, 50, 24,  8,   8, 1'b0,  8};
        rows[4] = '{120, 100, 1'b0, 82, 95, 24, 14,  96, 1'b1, 14};
        rows[5] = '{100, 100, 1'b0, 81, 88, 24,  8,  64, 1'b0,  8};
        rows[6] = '{200,  50, 1'b0,  0, -1, 24,  0, 176, 1'b1,  0};

        seed = 8'hA5;
        for (int k = 0; k < 8; k++) stream[k] = seed[k];
        for (int k = 8; k < 1024; k++) stream[k] = stream[k-8] ^ stream[k-6] ^ stream[k-4];

        reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        model_reset();
        #1;
        check("reset_outputs", {locked, err_pulse, err_count, bits_checked}, 34'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_row(i, rows[i]);

        // Asynchronous reset while locked
        do_reset();
        for (int k = 1; k <= 40; k++) step(1'b1, stream[k-1], 1'b0);
        check("pre_reset_locked", 34'(locked), 34'h1);
        check("pre_reset_bits", 34'(bits_checked), 34'd16);
        @(negedge clk);
        #2;
        reset = 1'b0; bit_valid = 1'b0;
        model_reset();
        #1;
        check("midreset_locked", 34'(locked), 34'h0);
        check("midreset_err_pulse", 34'(err_pulse), 34'h0);
        check("midreset_err_count", 34'(err_count), 34'h0);
        check("midreset_bits_checked", 34'(bits_checked), 34'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 41; k <= 60; k++) step(1'b1, stream[k-1], 1'b0);
        check("post_reset_unlocked", 34'(locked), 34'h0);

        // Clear on the same cycle as an error
        do_reset();
        for (int k = 1; k <= 30; k++) step(1'b1, stream[k-1], 1'b0);
        check("clr_pre_bits", 34'(bits_checked), 34'd6);
        step(1'b1, ~stream[30], 1'b1);
        check("clr_err_pulse", 34'(err_pulse), 34'h1);
        check("clr_err_count", 34'(err_count), 34'h0);
        check("clr_bits_checked", 34'(bits_checked), 34'h0);
        step(1'b1, stream[31], 1'b0);
        check("clr_next_pulse", 34'(err_pulse), 34'h0);
        check("clr_next_bits", 34'(bits_checked), 34'd1);
        check("clr_next_locked", 34'(locked), 34'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
